conv2_maxpooling: RTL and testbench

CONV2_MAXPOOLING -- requirements
Module: conv2_maxpooling

---
 rtl/conv2_maxpooling.sv | 136 +++++++++++++
 tb/tb_conv2_maxpooling.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_maxpooling.sv
// 2-D valid correlation of an image with a kernel, followed by stride-1 max pooling.
// Optional macro CONV2_RELU_EN clamps negative convolution results to zero.
module conv2_maxpooling #(
  parameter int SIZE        = 256,
  parameter int SIZEKer     = 3,
  parameter int SIZEPOOLING = 2,
  parameter int WIDTH_BIT   = 16,
  localparam int CONV_N     = SIZE - SIZEKer + 1,
  localparam int POOL_N     = CONV_N - SIZEPOOLING + 1
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic signed [WIDTH_BIT-1:0] inpMatrixI      [SIZE][SIZE],
  input  logic signed [WIDTH_BIT-1:0] inpKernel       [SIZEKer][SIZEKer],
  output logic signed [WIDTH_BIT-1:0] convIxKernelOut [CONV_N][CONV_N],
  output logic signed [WIDTH_BIT-1:0] maxPoolingOut   [POOL_N][POOL_N],
  output logic                        conv_done,
  output logic                        done
);

  localparam int ACC_W = 2 * WIDTH_BIT + $clog2(SIZEKer * SIZEKer);
  localparam int IW    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CW    = (CONV_N > 1) ? $clog2(CONV_N) : 1;
  localparam int PW    = (POOL_N > 1) ? $clog2(POOL_N) : 1;

  typedef enum logic [1:0] {CONV, POOL, DONE} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               r_q, r_d, c_q, c_d;
  logic signed [WIDTH_BIT-1:0] conv_q [CONV_N][CONV_N];
  logic signed [WIDTH_BIT-1:0] conv_d [CONV_N][CONV_N];
  logic signed [WIDTH_BIT-1:0] pool_q [POOL_N][POOL_N];
  logic signed [WIDTH_BIT-1:0] pool_d [POOL_N][POOL_N];
  logic                        conv_done_q, conv_done_d;
  logic                        done_q, done_d;

  logic signed [2*WIDTH_BIT-1:0] prod;
  logic signed [ACC_W-1:0]       acc;
  logic signed [WIDTH_BIT-1:0]   conv_val;
  logic signed [WIDTH_BIT-1:0]   pool_max;
  logic signed [WIDTH_BIT-1:0]   pool_cand;

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    conv_d      = conv_q;
    pool_d      = pool_q;
    conv_done_d = conv_done_q;
    done_d      = done_q;
    prod        = '0;
    acc         = '0;
    pool_max    = '0;
    pool_cand   = '0;

    for (int i = 0; i < SIZEKer; i++) begin
      for (int j = 0; j < SIZEKer; j++) begin
        prod = inpMatrixI[IW'(int'(r_q) + i)][IW'(int'(c_q) + j)] * inpKernel[i][j];
        acc  = acc + ACC_W'(prod);
      end
    end
    conv_val = acc[WIDTH_BIT-1:0];
`ifdef CONV2_RELU_EN
    if (conv_val[WIDTH_BIT-1]) conv_val = '0;
`endif

    // The pooling window reads the registered convolution array, never the live sum.
    pool_max = conv_q[r_q][c_q];
    for (int i = 0; i < SIZEPOOLING; i++) begin
      for (int j = 0; j < SIZEPOOLING; j++) begin
        pool_cand = conv_q[CW'(int'(r_q) + i)][CW'(int'(c_q) + j)];
        if (pool_cand > pool_max) pool_max = pool_cand;
      end
    end

    case (state_q)
      CONV: begin
        conv_d[r_q][c_q] = conv_val;
        if (c_q == CW'(CONV_N - 1)) begin
          c_d = '0;
          if (r_q == CW'(CONV_N - 1)) begin
            r_d         = '0;
            conv_done_d = 1'b1;
            state_d     = POOL;
          end else begin
            r_d = r_q + CW'(1);
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      POOL: begin
        pool_d[PW'(int'(r_q))][PW'(int'(c_q))] = pool_max;
        if (c_q == CW'(POOL_N - 1)) begin
          c_d = '0;
          if (r_q == CW'(POOL_N - 1)) begin
            r_d     = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            r_d = r_q + CW'(1);
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (nreset) begin
      state_q     <= CONV;
      r_q         <= '0;
      c_q         <= '0;
      conv_q      <= '{default: '0};
      pool_q      <= '{default: '0};
      conv_done_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      conv_q      <= conv_d;
      pool_q      <= pool_d;
      conv_done_q <= conv_done_d;
      done_q      <= done_d;
    end
  end

  assign convIxKernelOut = conv_q;
  assign maxPoolingOut   = pool_q;
  assign conv_done       = conv_done_q;
  assign done            = done_q;

endmodule

// File: tb/tb_conv2_maxpooling.sv
// Self-checking bench for conv2_maxpooling at SIZE=4, 3x3 kernel, 2x2 pooling.
module tb_conv2_maxpooling;

  localparam int SIZE = 4;
  localparam int K    = 3;
  localparam int P    = 2;
  localparam int W    = 16;
  localparam int CN   = SIZE - K + 1;
  localparam int PN   = CN - P + 1;
  localparam int CONV_EDGES = CN * CN;
  localparam int ALL_EDGES  = CN * CN + PN * PN;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                nreset = 1'b1;
  logic signed [W-1:0] img      [SIZE][SIZE];
  logic signed [W-1:0] ker      [K][K];
  logic signed [W-1:0] conv_o   [CN][CN];
  logic signed [W-1:0] pool_o   [PN][PN];
  logic                conv_done;
  logic                done;

  logic signed [W-1:0] exp_conv [CN][CN];
  logic signed [W-1:0] exp_pool [PN][PN];

  int checks   = 0;
  int failures = 0;

  conv2_maxpooling #(
    .SIZE(SIZE), .SIZEKer(K), .SIZEPOOLING(P), .WIDTH_BIT(W)
  ) dut (
    .clock(clock),
    .nreset(nreset),
    .inpMatrixI(img),
    .inpKernel(ker),
    .convIxKernelOut(conv_o),
    .maxPoolingOut(pool_o),
    .conv_done(conv_done),
    .done(done)
  );

  // Reference: textbook correlation with wide arithmetic, then truncation and max.
  task automatic compute_model();
    for (int r = 0; r < CN; r++) begin
      for (int c = 0; c < CN; c++) begin
        longint s;
        logic [63:0] sv;
        logic signed [W-1:0] t;
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            s += longint'(img[r+i][c+j]) * longint'(ker[i][j]);
        sv = s;
        t  = sv[W-1:0];
`ifdef CONV2_RELU_EN
        if (t < 0) t = 0;
`endif
        exp_conv[r][c] = t;
      end
    end
    for (int r = 0; r < PN; r++) begin
      for (int c = 0; c < PN; c++) begin
        int m;
        m = int'(exp_conv[r][c]);
        for (int i = 0; i < P; i++)
          for (int j = 0; j < P; j++)
            if (int'(exp_conv[r+i][c+j]) > m) m = int'(exp_conv[r+i][c+j]);
        exp_pool[r][c] = W'(m);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    nreset = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++) img[r][c] = 16'sd3;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) ker[i][j] = 16'sd2;
    apply_reset();
    for (int r = 0; r < CN; r++)
      for (int c = 0; c < CN; c++) begin
        checks++;
        if (conv_o[r][c] !== 16'sd0) begin
          failures++;
          $display("[TB] FAIL reset_conv[%0d][%0d] got=%0d want=0", r, c, conv_o[r][c]);
        end
      end
    checks++;
    if (pool_o[0][0] !== 16'sd0) begin
      failures++;
      $display("[TB] FAIL reset_pool got=%0d want=0", pool_o[0][0]);
    end
    checks++;
    if (conv_done !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got conv_done=%b done=%b want 0 0", conv_done, done);
    end
  endtask

  task automatic set_pattern(input int p);
    for (int r = 0; r < SIZE; r++)
      for (int c = 0; c < SIZE; c++)
        case (p)
          1:       img[r][c] = W'(4 * r + c);
          3:       img[r][c] = 16'sh7FFF;
          default: img[r][c] = 16'sd1;
        endcase
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        case (p)
          1:       ker[i][j] = (i == 1 && j == 1) ? 16'sd1 : 16'sd0;
          2:       ker[i][j] = -16'sd1;
          default: ker[i][j] = 16'sd1;
        endcase
    case (p)
      1: begin
        exp_conv[0][0] = 16'sd5; exp_conv[0][1] = 16'sd6;
        exp_conv[1][0] = 16'sd9; exp_conv[1][1] = 16'sd10;
        exp_pool[0][0] = 16'sd10;
      end
      2: begin
`ifdef CONV2_RELU_EN
        exp_conv = '{default: 16'sd0};
        exp_pool[0][0] = 16'sd0;
`else
        exp_conv = '{default: -16'sd9};
        exp_pool[0][0] = -16'sd9;
`endif
      end
      3: begin
        exp_conv = '{default: 16'sh7FF7};
        exp_pool[0][0] = 16'sh7FF7;
      end
      default: begin
        exp_conv = '{default: 16'sd9};
        exp_pool[0][0] = 16'sd9;
      end
    endcase
  endtask

  // Directed images: ones, ramp with identity kernel, negative kernel, overflow wrap.
  task automatic test_patterns();
    for (int p = 0; p < 4; p++) begin
      set_pattern(p);
      apply_reset();
      nreset = 1'b0;
      for (int e = 1; e <= ALL_EDGES; e++) begin
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (conv_done !== (e >= CONV_EDGES) || done !== (e >= ALL_EDGES)) begin
          failures++;
          $display("[TB] FAIL pat%0d_timing edge=%0d got conv_done=%b done=%b want %b %b",
                   p, e, conv_done, done, e >= CONV_EDGES, e >= ALL_EDGES);
        end
      end
      for (int r = 0; r < CN; r++)
        for (int c = 0; c < CN; c++) begin
          checks++;
          if (conv_o[r][c] !== exp_conv[r][c]) begin
            failures++;
            $display("[TB] FAIL pat%0d_conv[%0d][%0d] got=%0d want=%0d",
                     p, r, c, conv_o[r][c], exp_conv[r][c]);
          end
        end
      checks++;
      if (pool_o[0][0] !== exp_pool[0][0]) begin
        failures++;
        $display("[TB] FAIL pat%0d_pool got=%0d want=%0d", p, pool_o[0][0], exp_pool[0][0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    set_pattern(0);
    apply_reset();
    nreset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    nreset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (conv_o[0][0] !== 16'sd0 || conv_o[0][1] !== 16'sd0 || done !== 1'b0 || conv_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_clear got c00=%0d c01=%0d conv_done=%b done=%b want 0 0 0 0",
               conv_o[0][0], conv_o[0][1], conv_done, done);
    end
    nreset = 1'b0;
    for (int e = 1; e <= ALL_EDGES; e++) begin
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (conv_done !== (e >= CONV_EDGES) || done !== (e >= ALL_EDGES)) begin
        failures++;
        $display("[TB] FAIL midreset_timing edge=%0d got conv_done=%b done=%b", e, conv_done, done);
      end
    end
    checks++;
    if (conv_o[1][1] !== 16'sd9 || pool_o[0][0] !== 16'sd9) begin
      failures++;
      $display("[TB] FAIL midreset_values got c11=%0d pool=%0d want 9 9", conv_o[1][1], pool_o[0][0]);
    end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (done !== 1'b1 || conv_done !== 1'b1 || pool_o[0][0] !== 16'sd9 ||
          conv_o[0][0] !== 16'sd9 || conv_o[1][0] !== 16'sd9) begin
        failures++;
        $display("[TB] FAIL hold cycle=%0d got done=%b conv_done=%b pool=%0d c00=%0d c10=%0d want 1 1 9 9 9",
                 k, done, conv_done, pool_o[0][0], conv_o[0][0], conv_o[1][0]);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int edges;
      for (int r = 0; r < SIZE; r++)
        for (int c = 0; c < SIZE; c++)
          img[r][c] = (t < 3) ? W'($urandom) : W'($urandom_range(0, 40) - 20);
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          ker[i][j] = (t < 3) ? W'($urandom) : W'($urandom_range(0, 10) - 5);
      compute_model();
      apply_reset();
      nreset = 1'b0;
      edges = 0;
      while (done !== 1'b1 && edges < 50) begin
        @(posedge clock);
        @(negedge clock);
        edges++;
      end
      checks++;
      if (edges != ALL_EDGES) begin
        failures++;
        $display("[TB] FAIL rand%0d_latency got=%0d edges want=%0d", t, edges, ALL_EDGES);
      end
      for (int r = 0; r < CN; r++)
        for (int c = 0; c < CN; c++) begin
          checks++;
          if (conv_o[r][c] !== exp_conv[r][c]) begin
            failures++;
            $display("[TB] FAIL rand%0d_conv[%0d][%0d] got=%0d want=%0d",
                     t, r, c, conv_o[r][c], exp_conv[r][c]);
          end
        end
      checks++;
      if (pool_o[0][0] !== exp_pool[0][0]) begin
        failures++;
        $display("[TB] FAIL rand%0d_pool got=%0d want=%0d", t, pool_o[0][0], exp_pool[0][0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_mid_reset();
    test_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
